// File: rtl/comb_sweep_checker.sv
// Exhaustive input sweep with MISR compaction and golden-signature compare.
// Build macro: COMB_SWEEP_GRAY_EN selects Gray vector order (default binary).
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      begin a sweep (accepted in IDLE only)
//   abort      synchronous cancel of a running sweep
//   vec        stimulus to the block under test
//   resp       response from the block under test
//   busy       high throughout the sweep
//   done       one-cycle completion pulse
//   signature  current or final MISR value
//   pass       final signature matched GOLDEN
module comb_sweep_checker #(
    parameter int unsigned          IN_W   = 4,
    parameter int unsigned          OUT_W  = 2,
    parameter int unsigned          SIG_W  = 16,
    parameter logic [SIG_W-1:0]     POLY   = 16'h1021,
    parameter int unsigned          HOLD   = 1,
    parameter logic [SIG_W-1:0]     GOLDEN = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    output logic [IN_W-1:0]  vec,
    input  logic [OUT_W-1:0] resp,
    output logic             busy,
    output logic             done,
    output logic [SIG_W-1:0] signature,
    output logic             pass
);

    localparam int unsigned HW = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD - 1);
    localparam logic [IN_W:0] IDX_LAST = (IN_W + 1)'((1 << IN_W) - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [IN_W:0]    idx_q, idx_d;
    logic [HW-1:0]    hold_q, hold_d;
    logic [SIG_W-1:0] sig_q, sig_d;
    logic             pass_q, pass_d;
    logic [IN_W-1:0]  vec_q, vec_d;

    logic [SIG_W-1:0] resp_ext;
    logic [SIG_W-1:0] misr;
    logic [IN_W:0]    idx_inc;

    function automatic logic [IN_W-1:0] order(input logic [IN_W-1:0] i);
`ifdef COMB_SWEEP_GRAY_EN
        return i ^ (i >> 1);
`else
        return i;
`endif
    endfunction

    always_comb begin
        resp_ext = '0;
        resp_ext[OUT_W-1:0] = resp;
        misr = {sig_q[SIG_W-2:0], 1'b0}
             ^ (sig_q[SIG_W-1] ? POLY : '0)
             ^ resp_ext;
        idx_inc = idx_q + (IN_W + 1)'(1);
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        hold_d  = hold_q;
        sig_d   = sig_q;
        pass_d  = pass_q;
        vec_d   = vec_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    idx_d   = '0;
                    hold_d  = '0;
                    sig_d   = '0;
                    pass_d  = 1'b0;
                    vec_d   = order('0);
                end
            end
            RUN: begin
                // abort beats a coinciding final capture
                if (abort) begin
                    state_d = IDLE;
                    pass_d  = 1'b0;
                end else if (hold_q == HOLD_LAST) begin
                    hold_d = '0;
                    idx_d  = idx_inc;
                    sig_d  = misr;
                    if (idx_q == IDX_LAST) begin
                        // pass is valid during the done cycle
                        state_d = DONE;
                        pass_d  = (misr == GOLDEN);
                    end else begin
                        vec_d = order(idx_inc[IN_W-1:0]);
                    end
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            hold_q  <= '0;
            sig_q   <= '0;
            pass_q  <= 1'b0;
            vec_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            hold_q  <= hold_d;
            sig_q   <= sig_d;
            pass_q  <= pass_d;
            vec_q   <= vec_d;
        end
    end

    assign vec       = vec_q;
    assign busy      = (state_q == RUN);
    assign done      = (state_q == DONE);
    assign signature = sig_q;
    assign pass      = pass_q;

endmodule

// File: tb/tb_comb_sweep_checker.sv
// Directed bench for comb_sweep_checker: three instances cover
// AND/constant sweeps, HOLD=3 with ignored start, reset and abort.
module tb_comb_sweep_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

`ifdef COMB_SWEEP_GRAY_EN
    localparam logic [15:0] GOLD_A = 16'h0002;
`else
    localparam logic [15:0] GOLD_A = 16'h0001;
`endif

    // instance A: IN_W=2, OUT_W=1, HOLD=1
    logic        rst_n_a, start_a, abort_a, and_mode;
    logic [1:0]  vec_a;
    logic [0:0]  resp_a;
    logic        busy_a, done_a, pass_a;
    logic [15:0] sig_a;
    assign resp_a = and_mode ? (vec_a[1] & vec_a[0]) : 1'b1;

    comb_sweep_checker #(
        .IN_W(2), .OUT_W(1), .SIG_W(16), .POLY(16'h1021),
        .HOLD(1), .GOLDEN(GOLD_A)
    ) u_a (
        .clk(clk), .rst_n(rst_n_a), .start(start_a), .abort(abort_a),
        .vec(vec_a), .resp(resp_a), .busy(busy_a), .done(done_a),
        .signature(sig_a), .pass(pass_a)
    );

    // instance B: IN_W=4, HOLD=3, resp=0, GOLDEN=0
    logic        rst_n_b, start_b, abort_b;
    logic [3:0]  vec_b;
    logic [1:0]  resp_b;
    logic        busy_b, done_b, pass_b;
    logic [15:0] sig_b;
    assign resp_b = 2'b00;

    comb_sweep_checker #(
        .IN_W(4), .OUT_W(2), .SIG_W(16), .POLY(16'h1021),
        .HOLD(3), .GOLDEN(16'h0000)
    ) u_b (
        .clk(clk), .rst_n(rst_n_b), .start(start_b), .abort(abort_b),
        .vec(vec_b), .resp(resp_b), .busy(busy_b), .done(done_b),
        .signature(sig_b), .pass(pass_b)
    );

    // instance C: IN_W=4, HOLD=1, resp=1
    logic        rst_n_c, start_c, abort_c;
    logic [3:0]  vec_c;
    logic [1:0]  resp_c;
    logic        busy_c, done_c, pass_c;
    logic [15:0] sig_c;
    assign resp_c = 2'b01;

    comb_sweep_checker #(
        .IN_W(4), .OUT_W(2), .SIG_W(16), .POLY(16'h1021),
        .HOLD(1), .GOLDEN(16'h0000)
    ) u_c (
        .clk(clk), .rst_n(rst_n_c), .start(start_c), .abort(abort_c),
        .vec(vec_c), .resp(resp_c), .busy(busy_c), .done(done_c),
        .signature(sig_c), .pass(pass_c)
    );

    function automatic int ord(input int i);
`ifdef COMB_SWEEP_GRAY_EN
        return i ^ (i >> 1);
`else
        return i;
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        int dcount;
        rst_n_a = 1'b0; rst_n_b = 1'b0; rst_n_c = 1'b0;
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
        abort_a = 1'b0; abort_b = 1'b0; abort_c = 1'b0;
        and_mode = 1'b1;
        #12;
        chk("rst_vec", int'(vec_a), 0);
        chk("rst_busy", int'(busy_a), 0);
        chk("rst_done", int'(done_a), 0);
        chk("rst_sig", int'(sig_a), 0);
        chk("rst_pass", int'(pass_a), 0);
        rst_n_a = 1'b1; rst_n_b = 1'b1; rst_n_c = 1'b1;
        step();

        // A: AND sweep
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("and_vec", int'(vec_a), ord(i));
            chk("and_busy", int'(busy_a), 1);
            chk("and_nodone", int'(done_a), 0);
            step();
        end
        chk("and_done", int'(done_a), 1);
        chk("and_busy_lo", int'(busy_a), 0);
`ifdef COMB_SWEEP_GRAY_EN
        chk("and_sig", int'(sig_a), 16'h0002);
`else
        chk("and_sig", int'(sig_a), 16'h0001);
`endif
        chk("and_pass", int'(pass_a), 1);
        step();
        chk("idle_done", int'(done_a), 0);
        chk("idle_pass", int'(pass_a), 1);
        chk("idle_vec_hold", int'(vec_a), ord(3));

        // A: constant-one sweep, back-to-back start
        and_mode = 1'b0;
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        chk("one_vec0", int'(vec_a), 0);
        chk("one_pass_clr", int'(pass_a), 0);
        dcount = 0;
        while (busy_a && dcount < 20) begin
            dcount++;
            step();
        end
        chk("one_busy_cycles", dcount, 4);
        chk("one_done", int'(done_a), 1);
        chk("one_sig", int'(sig_a), 16'h000F);
        chk("one_pass", int'(pass_a), 0);

        // B: HOLD=3, extra start ignored
        start_b = 1'b1;
        step();
        start_b = 1'b0;
        for (int i = 0; i < 16; i++) begin
            for (int h = 0; h < 3; h++) begin
                chk("hold_vec", int'(vec_b), ord(i));
                chk("hold_busy", int'(busy_b), 1);
                start_b = (i == 2 && h == 1);
                step();
            end
        end
        start_b = 1'b0;
        chk("hold_done", int'(done_b), 1);
        chk("hold_busy_lo", int'(busy_b), 0);
        chk("hold_sig", int'(sig_b), 0);
        chk("hold_pass", int'(pass_b), 1);
        dcount = 0;
        for (int k = 0; k < 60; k++) begin
            step();
            if (done_b || busy_b) dcount++;
        end
        chk("hold_one_done", dcount, 0);

        // C: reset mid-sweep at index 7
        start_c = 1'b1;
        step();
        start_c = 1'b0;
        for (int i = 0; i < 7; i++) step();
        chk("rstm_vec7", int'(vec_c), ord(7));
        chk("rstm_busy", int'(busy_c), 1);
        rst_n_c = 1'b0;
        #1;
        chk("rstm_vec", int'(vec_c), 0);
        chk("rstm_busy0", int'(busy_c), 0);
        chk("rstm_done", int'(done_c), 0);
        chk("rstm_sig", int'(sig_c), 0);
        chk("rstm_pass", int'(pass_c), 0);
        step();
        rst_n_c = 1'b1;
        step();
        chk("rstm_idle_busy", int'(busy_c), 0);
        chk("rstm_idle_done", int'(done_c), 0);

        // C: abort at index 5
        start_c = 1'b1;
        step();
        start_c = 1'b0;
        for (int i = 0; i < 5; i++) step();
        chk("abt_vec5", int'(vec_c), ord(5));
        abort_c = 1'b1;
        step();
        abort_c = 1'b0;
        chk("abt_busy", int'(busy_c), 0);
        chk("abt_done", int'(done_c), 0);
        chk("abt_pass", int'(pass_c), 0);
        chk("abt_sig", int'(sig_c), 16'h001F);
        chk("abt_vec_hold", int'(vec_c), ord(5));
        dcount = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (done_c) dcount++;
        end
        chk("abt_no_done", dcount, 0);
        start_c = 1'b1;
        step();
        start_c = 1'b0;
        chk("abt_restart_vec", int'(vec_c), 0);
        chk("abt_restart_busy", int'(busy_c), 1);
        chk("abt_restart_sig", int'(sig_c), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
